// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the push-button interrupt controller.
// Contents:
//   irq_state_e  handshake FSM states (IDLE / REQ / SERVICE)
//   IRQ_VEC_TOP  bit of the interruptions vector that belongs to button0
//   IRQ_ID_W     width of the source index
//   IRQ_VEC_W    width of the interruptions vector
//   prio_pick    fixed-priority pick, lowest index wins
//   irq_vec      source index -> one-hot interruptions vector
//   id_onehot    source index -> one-hot pending mask
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam int IRQ_VEC_TOP = 6;
  localparam int IRQ_ID_W    = 2;
  localparam int IRQ_VEC_W   = 8;

  // Lowest set index wins; with nothing set the result is don't-care
  // because callers only use it when at least one bit is set.
  function automatic logic [IRQ_ID_W-1:0] prio_pick(input logic [3:0] elig);
    logic [IRQ_ID_W-1:0] id;
    if (elig[0]) begin
      id = 2'd0;
    end else if (elig[1]) begin
      id = 2'd1;
    end else if (elig[2]) begin
      id = 2'd2;
    end else begin
      id = 2'd3;
    end
    return id;
  endfunction

  // button0 sits at IRQ_VEC_TOP and higher indices move towards bit 0.
  function automatic logic [IRQ_VEC_W-1:0] irq_vec(input logic [IRQ_ID_W-1:0] id);
    logic [IRQ_VEC_W-1:0] top;
    top = 8'd1 << IRQ_VEC_TOP;
    return top >> id;
  endfunction

  function automatic logic [3:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    return 4'd1 << id;
  endfunction

endpackage

// File: rtl/interrupt_controller_button_debounce.sv
// Per-button input conditioning: 2-FF synchroniser, saturating debounce
// counter and a one-cycle pulse on the accepted 0->1 transition.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   btn    in   raw button, asynchronous to clk
//   rise   out  one-cycle pulse in the cycle the debounced level goes 0->1
module button_debounce #(
  parameter int DEB_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam logic [DEB_BITS-1:0] CNT_MAX = '1;

  logic                sync1_r;
  logic                sync2_r;
  logic                level_r;
  logic [DEB_BITS-1:0] cnt_r;
  logic                sat_s;

  assign sat_s = (cnt_r == CNT_MAX);

  // The pulse is taken combinationally from the acceptance condition so that
  // pending is written in the same edge the debounced level flips.
  assign rise = sync2_r & ~level_r & sat_s;

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Count while the synchronised input disagrees with the accepted level;
  // any agreement restarts the count, saturation accepts the new level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= '0;
    end else if (sat_s) begin
      level_r <= sync2_r;
      cnt_r   <= '0;
    end else begin
      cnt_r   <= cnt_r + DEB_BITS'(1);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Push-button interrupt controller. Debounced button rising edges are
// latched as pending requests; the enabled ones are offered to the CPU one
// at a time (button0 highest priority) through a req/ack/eoi handshake.
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   buttons        in   raw active-high buttons
//   mask_we        in   enable-mask write strobe
//   mask_in        in   new enable mask (1 = enabled)
//   irq_ack        in   CPU accepts the current request
//   irq_eoi        in   CPU finished the handler
//   irq_req        out  request valid
//   irq_id         out  index of the requested/serviced source
//   interruptions  out  one-hot vector, bit (6 - irq_id) while irq_req
//   pending        out  latched pending bits
//   mask           out  current enable mask
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int N_IRQ    = 4,
  parameter int DEB_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IRQ-1:0]     buttons,
  input  logic                 mask_we,
  input  logic [N_IRQ-1:0]     mask_in,
  input  logic                 irq_ack,
  input  logic                 irq_eoi,
  output logic                 irq_req,
  output logic [IRQ_ID_W-1:0]  irq_id,
  output logic [IRQ_VEC_W-1:0] interruptions,
  output logic [N_IRQ-1:0]     pending,
  output logic [N_IRQ-1:0]     mask
);

  logic [N_IRQ-1:0]     rise_s;
  logic [N_IRQ-1:0]     eligible_s;
  logic [N_IRQ-1:0]     clr_s;
  logic [N_IRQ-1:0]     pending_nxt_s;
  logic [N_IRQ-1:0]     pending_r;
  logic [N_IRQ-1:0]     mask_r;
  irq_state_e           state_r;
  irq_state_e           state_nxt_s;
  logic [IRQ_ID_W-1:0]  id_r;
  logic [IRQ_ID_W-1:0]  id_nxt_s;
  logic                 irq_req_r;
  logic [IRQ_VEC_W-1:0] vec_r;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_deb
    button_debounce #(
      .DEB_BITS (DEB_BITS)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (buttons[g]),
      .rise  (rise_s[g])
    );
  end

  assign eligible_s = pending_r & mask_r;

  // Next state and the pending-clear request. Only the REQ state looks at
  // irq_ack, so an eoi arriving together with ack is simply not seen.
  always_comb begin
    state_nxt_s = state_r;
    id_nxt_s    = id_r;
    clr_s       = '0;
    case (state_r)
      ST_IDLE: begin
        if (eligible_s != {N_IRQ{1'b0}}) begin
          state_nxt_s = ST_REQ;
          id_nxt_s    = prio_pick(eligible_s);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_nxt_s = ST_SERVICE;
          clr_s       = id_onehot(id_r);
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (irq_eoi) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // A new edge wins over the ack clear so a press during the ack is kept.
  always_comb begin
    pending_nxt_s = (pending_r & ~clr_s) | rise_s;
  end

  // FSM state and latched source index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      id_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      id_r    <= id_nxt_s;
    end
  end

  // Pending request latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // CPU-writable enable mask, all sources enabled out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= '1;
    end else if (mask_we) begin
      mask_r <= mask_in;
    end else begin
      mask_r <= mask_r;
    end
  end

  // Registered request outputs, decoded from the next state so that they
  // line up exactly with the REQ state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_req_r <= 1'b0;
      vec_r     <= '0;
    end else if (state_nxt_s == ST_REQ) begin
      irq_req_r <= 1'b1;
      vec_r     <= irq_vec(id_nxt_s);
    end else begin
      irq_req_r <= 1'b0;
      vec_r     <= '0;
    end
  end

  assign irq_req       = irq_req_r;
  assign irq_id        = id_r;
  assign interruptions = vec_r;
  assign pending       = pending_r;
  assign mask          = mask_r;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int DEB = 3;
  localparam int ACCEPT_RUN = 1 << DEB;   // stable samples needed after sync delay

  logic       clk;
  logic       reset;
  logic [3:0] buttons;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [7:0] interruptions;
  logic [3:0] pending;
  logic [3:0] mask;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.N_IRQ(4), .DEB_BITS(DEB)) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons       (buttons),
    .mask_we       (mask_we),
    .mask_in       (mask_in),
    .irq_ack       (irq_ack),
    .irq_eoi       (irq_eoi),
    .irq_req       (irq_req),
    .irq_id        (irq_id),
    .interruptions (interruptions),
    .pending       (pending),
    .mask          (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] m_pend, m_mask, m_lvl;
  int         m_run [4];
  bit         m_req, m_svc;
  int         m_id;
  logic [3:0] samp_q [$];

  logic [18:0] dut_out;
  assign dut_out = {irq_req, irq_id, interruptions, pending, mask};

  task automatic model_reset();
    m_pend = 4'd0; m_mask = 4'hF; m_lvl = 4'd0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_req = 1'b0; m_svc = 1'b0; m_id = 0;
    samp_q.delete();
  endtask

  // Buttons reach the debouncer two edges late; a new level is accepted
  // once that delayed stream has differed from it for ACCEPT_RUN edges.
  task automatic model_step();
    logic [3:0] dly, rise, elig, clr;
    samp_q.push_back(buttons);
    if (samp_q.size() > 3) void'(samp_q.pop_front());
    dly  = (samp_q.size() == 3) ? samp_q[0] : 4'd0;
    rise = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (dly[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == ACCEPT_RUN) begin
          m_lvl[i] = dly[i];
          m_run[i] = 0;
          rise[i]  = dly[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    elig = m_pend & m_mask;
    clr  = 4'd0;
    if (m_req) begin
      if (irq_ack) begin clr[m_id] = 1'b1; m_req = 1'b0; m_svc = 1'b1; end
    end else if (m_svc) begin
      if (irq_eoi) m_svc = 1'b0;
    end else if (elig != 4'd0) begin
      for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
      m_req = 1'b1;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we) m_mask = mask_in;
  endtask

  function automatic logic [18:0] model_out();
    logic [7:0] v;
    v = 8'd0;
    if (m_req) v[6 - m_id] = 1'b1;
    return {m_req, 2'(m_id), v, m_pend, m_mask};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    checks++;
    if ({irq_req, interruptions, pending, mask} !== {1'b0, 8'h00, 4'h0, 4'hF}) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", {irq_req, interruptions, pending, mask}, {1'b0, 8'h00, 4'h0, 4'hF});
    end
    tick();
    checks++;
    if (dut_out !== model_out()) begin errors++; $display("FAIL reset_model got=%h exp=%h", dut_out, model_out()); end
  endtask

  task automatic test_single();
    buttons = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (dut_out !== model_out()) begin errors++; $display("FAIL single_model c=%0d got=%h exp=%h", c, dut_out, model_out()); end
    end
    checks++;
    if ({pending, irq_req, irq_id, interruptions} !== {4'b0001, 1'b1, 2'd0, 8'h40}) begin
      errors++;
      $display("FAIL single_req got=%h exp=%h", {pending, irq_req, irq_id, interruptions}, {4'b0001, 1'b1, 2'd0, 8'h40});
    end
    buttons = 4'b0000;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if ({pending, irq_req, interruptions} !== {4'b0000, 1'b0, 8'h00}) begin
      errors++; $display("FAIL single_ack got=%h exp=%h", {pending, irq_req, interruptions}, {4'b0000, 1'b0, 8'h00});
    end
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (dut_out !== model_out()) begin errors++; $display("FAIL single_idle c=%0d got=%h exp=%h", c, dut_out, model_out()); end
    end
  endtask

  task automatic test_glitch();
    int widths [2] = '{1, 7};
    for (int w = 0; w < 2; w++) begin
      buttons = 4'b0100;
      for (int c = 0; c < widths[w]; c++) tick();
      buttons = 4'b0000;
      for (int c = 0; c < 14; c++) begin
        tick();
        checks++;
        if (dut_out !== model_out()) begin errors++; $display("FAIL glitch_model w=%0d got=%h exp=%h", widths[w], dut_out, model_out()); end
      end
      checks++;
      if ({pending, irq_req} !== 5'b0) begin
        errors++; $display("FAIL glitch_w%0d got=%h exp=%h", widths[w], {pending, irq_req}, 5'b0);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit seen;
    buttons = 4'b1010;
    for (int c = 0; c < 12; c++) tick();
    buttons = 4'b0000;
    checks++;
    if ({irq_req, irq_id, interruptions} !== {1'b1, 2'd1, 8'h20}) begin
      errors++; $display("FAIL simul_first got=%h exp=%h", {irq_req, irq_id, interruptions}, {1'b1, 2'd1, 8'h20});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      tick();
      seen = irq_req;
    end
    checks++;
    if ({seen, irq_id, interruptions} !== {1'b1, 2'd3, 8'h08}) begin
      errors++; $display("FAIL simul_second got=%h exp=%h", {seen, irq_id, interruptions}, {1'b1, 2'd3, 8'h08});
    end
    checks++;
    if (dut_out !== model_out()) begin errors++; $display("FAIL simul_model got=%h exp=%h", dut_out, model_out()); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    for (int c = 0; c < 12; c++) tick();
  endtask

  task automatic test_mask();
    mask_in = 4'b1110; mask_we = 1'b1; tick(); mask_we = 1'b0;
    buttons = 4'b0001;
    for (int c = 0; c < 12; c++) tick();
    buttons = 4'b0000;
    checks++;
    if ({pending[0], irq_req, mask} !== {1'b1, 1'b0, 4'b1110}) begin
      errors++; $display("FAIL mask_blocked got=%h exp=%h", {pending[0], irq_req, mask}, {1'b1, 1'b0, 4'b1110});
    end
    mask_in = 4'hF; mask_we = 1'b1; tick(); mask_we = 1'b0;
    tick();
    checks++;
    if ({irq_req, irq_id} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL mask_release got=%h exp=%h", {irq_req, irq_id}, {1'b1, 2'd0});
    end
    // Masking while requesting must not withdraw the request.
    mask_in = 4'h0; mask_we = 1'b1; tick(); mask_we = 1'b0;
    tick();
    checks++;
    if ({irq_req, irq_id, mask} !== {1'b1, 2'd0, 4'h0}) begin
      errors++; $display("FAIL mask_in_req got=%h exp=%h", {irq_req, irq_id, mask}, {1'b1, 2'd0, 4'h0});
    end
    mask_in = 4'hF; mask_we = 1'b1;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; mask_we = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (dut_out !== model_out()) begin errors++; $display("FAIL mask_model got=%h exp=%h", dut_out, model_out()); end
  endtask

  task automatic test_ack_eoi_together();
    buttons = 4'b0011;
    for (int c = 0; c < 12; c++) tick();
    buttons = 4'b0000;
    irq_ack = 1'b1; irq_eoi = 1'b1; tick(); irq_ack = 1'b0; irq_eoi = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if ({irq_req, pending} !== {1'b0, 4'b0010}) begin
      errors++; $display("FAIL ackeoi_stay got=%h exp=%h", {irq_req, pending}, {1'b0, 4'b0010});
    end
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    tick();
    checks++;
    if ({irq_req, irq_id, interruptions} !== {1'b1, 2'd1, 8'h20}) begin
      errors++; $display("FAIL ackeoi_next got=%h exp=%h", {irq_req, irq_id, interruptions}, {1'b1, 2'd1, 8'h20});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_set_clear_same_cycle();
    buttons = 4'b0001;
    for (int c = 0; c < 12; c++) tick();
    buttons = 4'b0000;
    for (int c = 0; c < 12; c++) tick();      // level back to 0, still in REQ
    buttons = 4'b0001;
    for (int c = 0; c < 9; c++) tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;   // accept edge coincides with ack
    checks++;
    if ({irq_req, pending} !== {1'b0, 4'b0001}) begin
      errors++; $display("FAIL setclr got=%h exp=%h", {irq_req, pending}, {1'b0, 4'b0001});
    end
    checks++;
    if (dut_out !== model_out()) begin errors++; $display("FAIL setclr_model got=%h exp=%h", dut_out, model_out()); end
    buttons = 4'b0000;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_reset_mid();
    mask_in = 4'b0111; mask_we = 1'b1; tick(); mask_we = 1'b0;
    buttons = 4'b0101;
    for (int c = 0; c < 12; c++) tick();
    buttons = 4'b0000;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if ({irq_req, pending} !== {1'b0, 4'b0100}) begin
      errors++; $display("FAIL resetmid_pre got=%h exp=%h", {irq_req, pending}, {1'b0, 4'b0100});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dut_out !== {1'b0, 2'd0, 8'h00, 4'h0, 4'hF}) begin
      errors++; $display("FAIL resetmid_clear got=%h exp=%h", dut_out, {1'b0, 2'd0, 8'h00, 4'h0, 4'hF});
    end
    reset = 1'b1;
    tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (dut_out !== {1'b0, 2'd0, 8'h00, 4'h0, 4'hF}) begin
        errors++; $display("FAIL resetmid_after got=%h exp=%h", dut_out, {1'b0, 2'd0, 8'h00, 4'h0, 4'hF});
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        buttons[b] = ~buttons[b];
      end
      mask_we = ($urandom_range(0, 31) == 0);
      mask_in = 4'($urandom);
      irq_ack = ($urandom_range(0, 3) == 0);
      irq_eoi = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (dut_out !== model_out()) begin errors++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_out, model_out()); end
    end
    mask_we = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0; buttons = 4'b0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset = 1'b0; buttons = 4'b0000; mask_we = 1'b0; mask_in = 4'h0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_simultaneous();
    test_mask();
    test_ack_eoi_together();
    test_set_clear_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
